// File: rtl/uart_pkg.sv
// Shared UART frame codes: FSM states, parity modes and stop-length modes.
// Used by uart_tx_frame now and by uart_rx_frame later, so the encodings must stay fixed.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  // Code 2'b11 is reserved and behaves as PAR_NONE.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side handshake of the UART transmitter: write request, data word, frame config and status.
// The host drives through 'master'; the transmitter receives through 'slave'.
interface uart_tx_frame_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic [1:0]      par_mode;
  logic [1:0]      stop_mode;
  logic            tx_ready;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output tx_start, din, par_mode, stop_mode,
    input  tx_ready, tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_start, din, par_mode, stop_mode,
    output tx_ready, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_holdreg.sv
// One-entry data buffer; a write lands one clk after wr_vld && wr_rdy, pop frees it at the next edge.
// Writes while full are dropped; wr_rdy is a flop holding the inverse of the next valid bit.
module uart_tx_holdreg #(
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_vld,
  input  logic [DBIT-1:0] wr_dat,
  input  logic            pop,
  output logic            rd_vld,
  output logic [DBIT-1:0] rd_dat,
  output logic            wr_rdy
);
  logic vld_d;
  logic wr_ok;

  assign wr_ok = wr_vld & wr_rdy;

  // Pop and write never coincide: writes need the buffer empty, pops need it full.
  always_comb begin
    vld_d = rd_vld;
    if (pop)   vld_d = 1'b0;
    if (wr_ok) vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= 1'b0;
      wr_rdy <= 1'b1;
      rd_dat <= '0;
    end else begin
      rd_vld <= vld_d;
      wr_rdy <= ~vld_d;
      if (wr_ok) rd_dat <= wr_dat;
    end
  end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: DBIT data bits, runtime parity/stop, buffered so frames can go out back-to-back.
// tx falls two clks after an idle write is sampled; host throttled by tx_ready (one-entry buffer).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int OVS  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_tick,
  uart_tx_frame_if.slave host,
  output logic           tx
);
  localparam int TW = $clog2(2 * OVS);
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TW-1:0] BIT_LAST    = TW'(OVS - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(3 * OVS / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVS - 1);
  localparam logic [BW-1:0] DBIT_LAST   = BW'(DBIT - 1);

  uart_state_t     state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d, stop_last;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d, hold_dat;
  logic [1:0]      pmode_q, pmode_d, smode_q, smode_d;
  logic            par_q, par_d, tx_d, done_q, done_d;
  logic            hold_vld, load;

  uart_tx_holdreg #(.DBIT(DBIT)) u_holdreg (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (host.tx_start),
    .wr_dat (host.din),
    .pop    (load),
    .rd_vld (hold_vld),
    .rd_dat (hold_dat),
    .wr_rdy (host.tx_ready)
  );

  assign host.tx_busy      = (state_q != ST_IDLE);
  assign host.tx_done_tick = done_q;

  always_comb begin
    case (smode_q)
      STOP_1:   stop_last = BIT_LAST;
      STOP_1P5: stop_last = STOP15_LAST;
      default:  stop_last = STOP2_LAST;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pmode_d = pmode_q;
    smode_d = smode_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: load = hold_vld;
      ST_START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == BIT_LAST) begin
            state_d = ST_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        tx_d = shreg_q[0];
        if (s_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == DBIT_LAST)
              state_d = par_enabled(pmode_q) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (s_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == BIT_LAST) begin
            state_d = ST_STOP;
            tick_d  = '0;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == stop_last) begin
            done_d  = 1'b1;
            tick_d  = '0;
            state_d = ST_IDLE;
            load    = hold_vld;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load from IDLE or from the last stop tick starts the next frame immediately.
    if (load) begin
      state_d = ST_START;
      tick_d  = '0;
      bit_d   = '0;
      shreg_d = hold_dat;
      pmode_d = host.par_mode;
      smode_d = host.stop_mode;
      par_d   = (host.par_mode == PAR_ODD) ? ~(^hold_dat) : ^hold_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      pmode_q <= PAR_NONE;
      smode_q <= STOP_1;
      tx      <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      pmode_q <= pmode_d;
      smode_q <= smode_d;
      tx      <= tx_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: table of frames plus hand sequences, line decoded per s_tick against a queue.
module tb_uart_tx_frame;
  localparam int DBIT = 8;
  localparam int OVS  = 16;

  typedef struct {
    logic [7:0] din;
    logic [1:0] pm;
    logic [1:0] sm;
    logic [1:0] par;   // expected parity bit, 2 = no parity bit in the frame
    int         len;   // expected frame length in s_ticks
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic tx;
  int   vec_cnt = 0, miss_cnt = 0, cyc = 0;
  int   done_cnt = 0, frames_done = 0;
  vec_t exp_q[$];
  vec_t tbl[10];

  uart_tx_frame_if #(.DBIT(DBIT)) bus ();

  uart_tx_frame #(.DBIT(DBIT), .OVS(OVS)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .host   (bus),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1 s_tick = ~s_tick;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s: got timeout, expected DUT event", name);
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset && bus.tx_done_tick === 1'b1) done_cnt++;
  end

  // Line monitor: one sample per s_tick, frames compared against the queue head.
  initial begin
    vec_t cur;
    int   idx, gap, bad, seg;
    bit   in_frame, done_pend, expect_b2b;
    logic e;
    idx = 0; gap = 0; bad = -1; in_frame = 0; done_pend = 0; expect_b2b = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 0; done_pend = 0; expect_b2b = 0; gap = 0; idx = 0;
      end else begin
        if (done_pend) begin
          done_pend = 0;
          chk("done_tick", int'(bus.tx_done_tick), 1);
          chk("busy_after_stop", int'(bus.tx_busy), int'(exp_q.size() > 0));
          expect_b2b = (exp_q.size() > 0);
          gap = 0;
        end
        if (s_tick) begin
          if (!in_frame) begin
            if (tx == 1'b0) begin
              if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_frame: got start bit, expected idle line");
                cur = '{8'h00, 2'd0, 2'd0, 2'd2, 160};
              end else begin
                cur = exp_q.pop_front();
                if (expect_b2b) chk("b2b_gap", gap, 0);
              end
              expect_b2b = 0;
              in_frame = 1; idx = 0; bad = -1;
            end else begin
              gap++;
            end
          end
          if (in_frame) begin
            seg = idx / OVS;
            if (seg == 0) e = 1'b0;
            else if (seg <= DBIT) e = cur.din[seg-1];
            else if (cur.par != 2'd2 && seg == DBIT + 1) e = cur.par[0];
            else e = 1'b1;
            if (tx !== e && bad < 0) bad = idx;
            idx++;
            if (idx == cur.len) begin
              chk($sformatf("frame_%02h_first_bad_tick", cur.din), bad, -1);
              in_frame = 0;
              done_pend = 1;
              frames_done++;
            end
          end
        end
      end
    end
  end

  task automatic write(input vec_t v);
    int n = 0;
    @(posedge clk); #2;
    while ((bus.tx_ready !== 1'b1 || s_tick) && n < 4000) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 4000) begin
      timeout_fail("write_wait_ready");
      return;
    end
    bus.din = v.din;
    bus.par_mode = v.pm;
    bus.stop_mode = v.sm;
    bus.tx_start = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #2;
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() > 0 || bus.tx_busy) && n < 5000);
    if (n >= 5000) timeout_fail("wait_idle");
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n, hi, t0;
    bus.tx_start = 1'b0;
    bus.din = '0;
    bus.par_mode = 2'b00;
    bus.stop_mode = 2'b00;

    tbl[0] = '{8'hA5, 2'd0, 2'd0, 2'd2, 160};
    tbl[1] = '{8'h07, 2'd1, 2'd0, 2'd1, 176};
    tbl[2] = '{8'h03, 2'd2, 2'd0, 2'd1, 176};
    tbl[3] = '{8'h03, 2'd1, 2'd0, 2'd0, 176};
    tbl[4] = '{8'h00, 2'd0, 2'd1, 2'd2, 168};
    tbl[5] = '{8'h00, 2'd0, 2'd2, 2'd2, 176};
    tbl[6] = '{8'h5A, 2'd3, 2'd3, 2'd2, 176};
    tbl[7] = '{8'hFF, 2'd2, 2'd0, 2'd1, 176};
    tbl[8] = '{8'h80, 2'd1, 2'd1, 2'd1, 184};
    tbl[9] = '{8'h3C, 2'd2, 2'd2, 2'd1, 192};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_ready", int'(bus.tx_ready), 1);
    chk("reset_busy", int'(bus.tx_busy), 0);
    chk("reset_done", int'(bus.tx_done_tick), 0);
    @(posedge clk); #2 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      write(tbl[i]);
      if (i == 0) begin
        @(negedge clk);
        chk("ready_after_write", int'(bus.tx_ready), 0);
        @(negedge clk);
        chk("lat_tx_edge1", int'(tx), 1);
        chk("lat_busy_edge1", int'(bus.tx_busy), 1);
        @(negedge clk);
        chk("lat_tx_edge2", int'(tx), 0);
      end
      wait_idle();
    end

    // Back-to-back: second write during DATA, with different config on the pins.
    write('{8'h11, 2'd0, 2'd0, 2'd2, 160});
    repeat (60) @(posedge clk);
    write('{8'h22, 2'd1, 2'd2, 2'd0, 192});
    n = 0; hi = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (bus.tx_done_tick) break;
      if (bus.tx_ready) hi++;
    end
    if (n >= 2000) timeout_fail("b2b_done_wait");
    chk("b2b_ready_held_low", hi, 0);
    chk("b2b_ready_after_load", int'(bus.tx_ready), 1);
    wait_idle();

    // Write while full is dropped.
    write('{8'h44, 2'd0, 2'd0, 2'd2, 160});
    write('{8'h55, 2'd1, 2'd0, 2'd0, 176});
    @(posedge clk); #2;
    chk("ready_low_before_ignored", int'(bus.tx_ready), 0);
    bus.din = 8'h33;
    bus.tx_start = 1'b1;
    @(posedge clk); #2;
    bus.tx_start = 1'b0;
    wait_idle();

    // Reset in DATA bit 4 with a second frame buffered.
    write('{8'h66, 2'd0, 2'd0, 2'd2, 160});
    t0 = cyc;
    write('{8'h77, 2'd0, 2'd0, 2'd2, 160});
    while (cyc < t0 + 172) @(posedge clk);
    #2;
    chk("pre_reset_tx_bit4", int'(tx), 0);
    chk("pre_reset_busy", int'(bus.tx_busy), 1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_tx", int'(tx), 1);
    chk("mid_reset_ready", int'(bus.tx_ready), 1);
    chk("mid_reset_busy", int'(bus.tx_busy), 0);
    repeat (400) @(posedge clk);
    write('{8'hC3, 2'd2, 2'd0, 2'd1, 176});
    wait_idle();

    chk("done_pulse_count", done_cnt, frames_done);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
